vga_scanout: RTL and testbench
==============================

# vga_scanout

Consumer end of the pixel FIFO: pops RGB565 pixels written by the scanline renderer and drives a 640x480@60 VGA raster (hsync, vsync, RGB). Also generates the once-per-frame `trigger` pulse that starts the renderer's frame, closing the loop between renderer and display. `clk` is the pixel clock (25.175 MHz nominal).

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, active level of hsync/vsync (0 = negative)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pixel clock
- reset  in  1  synchronous active-high reset
- fifo_empty  in  1  FIFO has no data
- fifo_read  out  1  pop request; data valid on `fifo_data` the next cycle
- fifo_data  in  16  RGB565 pixel {r[4:0], g[5:0], b[4:0]}
- trigger  out  1  one-cycle frame-start pulse to renderer
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- red  out  5  / green  out  6 / blue  out  5  pixel colour, zero outside active
- underrun  out  1  sticky: active pixel requested while FIFO empty

## Operation
- Counters: `hc` 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), `vc` 0..V_TOTAL-1 (525). `hc` wraps to 0 and `vc` increments when `hc == H_TOTAL-1`; `vc` wraps to 0 after `V_TOTAL-1`. Widths 10 bits each.
- Active region: `hc < H_ACTIVE && vc < V_ACTIVE`. Sync: hsync asserted for `H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC`; vsync likewise on `vc`.
- FSM, 2 states:
  - IDLE: after reset. Counters run, syncs valid, RGB black, no FIFO reads. At `vc == V_ACTIVE+V_FP && hc == 0` (vsync start line) pulse `trigger`, go ARMED.
  - ARMED: `fifo_read = active && !fifo_empty`. `trigger` pulses at the same point every frame. Stays ARMED until reset.
- Trigger fires in vertical blanking so the renderer has the remainder of blanking (35 lines) to prefill the FIFO before line 0.
- Underrun: active && ARMED && fifo_empty -> no pop, that pixel is black, `underrun` set; stays set until reset. Raster timing never stalls.
- RGB forced to 0 whenever the pixel is not active or not ARMED, regardless of `fifo_data`.

## Timing
- One-stage output pipeline: counter position P at cycle t issues `fifo_read` at t; `fifo_data` valid t+1; `red/green/blue`, `hsync`, `vsync` for position P all registered and presented together at t+1 (syncs delayed by same stage to stay aligned).
- `trigger` is combinationally decoded from counters, registered, high exactly 1 cycle per frame.
- Reset values: hc=0, vc=0, state IDLE, fifo_read=0, trigger=0, red/green/blue=0, underrun=0, hsync/vsync = inactive level (`!SYNC_POL`).
- Reset mid-frame: everything returns to the above on the next edge; no trigger until the next vsync-start line; renderer/FIFO resync is the parent's responsibility.
- Boundaries: last active pixel hc=639 reads, hc=640 does not; line 479 is the last line read; fifo_empty rising in the same cycle as a read request suppresses that read (no read on empty, ever).

## Structure
- Shared package `vga_pkg`: default 640x480 timing constants, H_TOTAL/V_TOTAL derivation, RGB565 field widths/slices.
- Natural sub-module: `vga_timing` (counters, active/hsync/vsync/trigger-point decode), reusable by other display blocks; `vga_scanout` adds FSM, FIFO handshake, pipeline register, underrun.

## Test plan
- Reset release, FIFO permanently empty -> hsync period 800 clk, low 96; vsync period 420000 clk, low 1600; no fifo_read; RGB=0; first trigger at cycle 490*800+1 after reset.
- FIFO model prefilled after first trigger with pixel = {y[4:0], x[5:0], 5'h1F} -> every active pixel matches expected colour one cycle after read; exactly 307200 reads per frame; none in blanking.
- FIFO empty for 3 cycles at (x=100, y=10) -> those 3 pixels black, next pixel is the next FIFO word, `underrun`=1 and stays 1 through following frames.
- Assert reset at (x=300, y=200) for 1 cycle -> outputs at reset values next cycle, state IDLE, no reads until the next trigger.
- SYNC_POL=1 -> hsync/vsync high during sync, low at reset; all other timing identical.
- Check alignment: hsync falling edge lands 16 clk after the last active RGB output of the line (x=639), on the pipelined outputs.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, counter width, RGB565 layout,
// and the scanout state encoding.
package vga_pkg;

    // Sum of the four segments of one timing axis (active, front porch, sync, back porch).
    function automatic int unsigned vga_total(input int unsigned act,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL =
        vga_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int unsigned VGA_V_TOTAL =
        vga_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

    localparam int CNT_W = 10;

    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;

    // RGB565 word as written by the renderer: {r[4:0], g[5:0], b[4:0]}.
    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } scan_state_e;

endpackage

// File: rtl/vga_timing.sv
// Raster position counters and decode of active area, sync windows and the
// frame-start (first vsync line) point. Reusable by any display-side block.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic clk,
    input  logic reset,
    output logic active_o,
    output logic hsync_act_o,
    output logic vsync_act_o,
    output logic trig_pt_o
);

    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;

    // Next raster position: hc wraps each line, vc advances on the last pixel of a line.
    always_comb begin
        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign active_o    = (hc_q < H_ACT_END) && (vc_q < V_ACT_END);
    assign hsync_act_o = (hc_q >= H_SYNC_BEG) && (hc_q < H_SYNC_END);
    assign vsync_act_o = (vc_q >= V_SYNC_BEG) && (vc_q < V_SYNC_END);
    assign trig_pt_o   = (vc_q == V_SYNC_BEG) && (hc_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: pops RGB565 pixels from the renderer FIFO during the active area,
// drives a registered raster (syncs + colour), pulses trigger once per frame at
// the start of vsync, and flags any active pixel that found the FIFO empty.
//
//   state    | meaning
//   ---------+----------------------------------------------------------------
//   ST_IDLE  | after reset; raster runs, output black, no pops until first trigger
//   ST_ARMED | renderer started; pop one word per active pixel, stay until reset
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           fifo_empty,
    output logic           fifo_read,
    input  logic [15:0]    fifo_data,
    output logic           trigger,
    output logic           hsync,
    output logic           vsync,
    output logic [R_W-1:0] red,
    output logic [G_W-1:0] green,
    output logic [B_W-1:0] blue,
    output logic           underrun
);

    logic active, hsync_act, vsync_act, trig_pt;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .active_o    (active),
        .hsync_act_o (hsync_act),
        .vsync_act_o (vsync_act),
        .trig_pt_o   (trig_pt)
    );

    scan_state_e state_q, state_d;
    logic        rd_q;
    logic        hsync_q, vsync_q;
    logic        trigger_q;
    logic        underrun_q, underrun_d;
    logic        starve;
    rgb565_t     pix;

    // Next state and FIFO handshake; a pop is never issued while reset is held.
    always_comb begin
        state_d   = state_q;
        fifo_read = 1'b0;
        starve    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_pt) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                fifo_read = active && !fifo_empty;
                starve    = active && fifo_empty;
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) fifo_read = 1'b0;
        underrun_d = underrun_q | starve;
    end

    // State, pipeline stage (read-valid + syncs), trigger pulse and sticky underrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_q       <= 1'b0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
            trigger_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= fifo_read;
            hsync_q    <= hsync_act ? SYNC_POL : ~SYNC_POL;
            vsync_q    <= vsync_act ? SYNC_POL : ~SYNC_POL;
            trigger_q  <= trig_pt;
            underrun_q <= underrun_d;
        end
    end

    // FIFO output register supplies the word one cycle after the pop, aligned with rd_q.
    assign pix      = rgb565_t'(fifo_data);
    assign red      = rd_q ? pix.r : '0;
    assign green    = rd_q ? pix.g : '0;
    assign blue     = rd_q ? pix.b : '0;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign trigger  = trigger_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout using a shrunken raster (16 x 9, frame = 144 clk)
// so several frames fit in a short run. Sync-active-low DUT gets a FIFO model;
// a second sync-active-high DUT sees a permanently empty FIFO.
module tb_vga_scanout;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fill = 1'b0;
    logic        force_empty = 1'b0;
    logic        fifo_empty;
    logic        fifo_read;
    logic [15:0] fifo_data;
    logic        trigger, hsync, vsync, underrun;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;

    logic        fifo_read_p, trigger_p, hsync_p, vsync_p, underrun_p;
    logic [4:0]  red_p;
    logic [5:0]  green_p;
    logic [4:0]  blue_p;

    int rd_idx;
    int cyc;
    int n_cmp = 0;
    int n_bad = 0;
    int hs_low, vs_low, nrd, nz;

    assign fifo_empty = !fill || force_empty;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .fifo_data  (fifo_data),
        .trigger    (trigger),
        .hsync      (hsync),
        .vsync      (vsync),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .underrun   (underrun)
    );

    vga_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b1)
    ) dut_pos (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (1'b1),
        .fifo_read  (fifo_read_p),
        .fifo_data  (16'h0000),
        .trigger    (trigger_p),
        .hsync      (hsync_p),
        .vsync      (vsync_p),
        .red        (red_p),
        .green      (green_p),
        .blue       (blue_p),
        .underrun   (underrun_p)
    );

    // FIFO word n holds the pixel of raster-order index n: {y[4:0], x[5:0], 5'h1F}.
    function automatic logic [15:0] word(input int n);
        int x, y;
        logic [4:0] yy;
        logic [5:0] xx;
        x  = n % HA;
        y  = (n / HA) % VA;
        yy = y[4:0];
        xx = x[5:0];
        return {yy, xx, 5'h1F};
    endfunction

    // FIFO model: registered read data, one word per pop.
    always @(posedge clk) begin
        if (reset) begin
            rd_idx    <= 0;
            fifo_data <= '0;
        end else if (fifo_read) begin
            fifo_data <= word(rd_idx);
            rd_idx    <= rd_idx + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cyc %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int q, x, y;
        logic [15:0] exp_pix;
        cyc = 0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check_eq("rst_hsync", hsync, 1);
        check_eq("rst_vsync", vsync, 1);
        check_eq("rst_hsync_pos", hsync_p, 0);
        check_eq("rst_vsync_pos", vsync_p, 0);
        check_eq("rst_trigger", trigger, 0);
        check_eq("rst_rgb", {red, green, blue}, 0);
        check_eq("rst_fifo_read", fifo_read, 0);
        check_eq("rst_underrun", underrun, 0);

        // ---------------- phase 1: FIFO permanently empty ----------------
        reset = 1'b0;
        cyc = 0;
        hs_low = 0; vs_low = 0; nz = 0;
        nrd = int'(fifo_read);
        while (cyc < 290) begin
            tick();
            if (cyc <= 144) begin
                if (!hsync) hs_low++;
                if (!vsync) vs_low++;
            end
            if (cyc < 288) nrd += int'(fifo_read);
            if ({red, green, blue} != 16'h0) nz++;
            if (cyc == 10)  check_eq("hsync_before", hsync, 1);
            if (cyc == 11)  check_eq("hsync_fall", hsync, 0);
            if (cyc == 11)  check_eq("hsync_pos_rise", hsync_p, 1);
            if (cyc == 13)  check_eq("hsync_last", hsync, 0);
            if (cyc == 14)  check_eq("hsync_rise", hsync, 1);
            if (cyc == 14)  check_eq("hsync_pos_fall", hsync_p, 0);
            if (cyc == 80)  check_eq("trig_early", trigger, 0);
            if (cyc == 80)  check_eq("vsync_before", vsync, 1);
            if (cyc == 81)  check_eq("trig_first", trigger, 1);
            if (cyc == 81)  check_eq("trig_pos", trigger_p, 1);
            if (cyc == 81)  check_eq("vsync_fall", vsync, 0);
            if (cyc == 81)  check_eq("vsync_pos_rise", vsync_p, 1);
            if (cyc == 82)  check_eq("trig_one_cycle", trigger, 0);
            if (cyc == 112) check_eq("vsync_last", vsync, 0);
            if (cyc == 113) check_eq("vsync_rise", vsync, 1);
            if (cyc == 144) check_eq("underrun_pre", underrun, 0);
            if (cyc == 145) check_eq("underrun_empty", underrun, 1);
            if (cyc == 145) check_eq("underrun_pos", underrun_p, 1);
            if (cyc == 145) check_eq("pos_quiet", {fifo_read_p, red_p, green_p, blue_p}, 0);
            if (cyc == 225) check_eq("trig_second", trigger, 1);
        end
        check_eq("hsync_low_count", hs_low, 27);
        check_eq("vsync_low_count", vs_low, 32);
        check_eq("empty_reads", nrd, 0);
        check_eq("empty_rgb_nonzero", nz, 0);

        // ---------------- phase 2: FIFO filled after first trigger ----------------
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cyc = 0;
        nrd = 0;
        while (cyc < 288) begin
            tick();
            if (cyc >= 144 && cyc < 288) nrd += int'(fifo_read);
            if (cyc >= 145) begin
                q = cyc - 1 - 144;
                x = q % 16;
                y = q / 16;
                exp_pix = (x < HA && y < VA) ? word(y * HA + x) : 16'h0;
                check_eq("pixel", {red, green, blue}, exp_pix);
            end
            if (cyc == 81)  fill = 1'b1;
            if (cyc == 151) check_eq("read_x7", fifo_read, 1);
            if (cyc == 152) check_eq("read_x8", fifo_read, 0);
            if (cyc == 155) check_eq("hsync_after_active", hsync, 0);
            if (cyc == 199) check_eq("read_last_line", fifo_read, 1);
            if (cyc == 208) check_eq("read_line4", fifo_read, 0);
        end
        check_eq("reads_frame", nrd, 32);

        // ---------------- phase 3: 3-cycle starvation at (2,1) ----------------
        nrd = int'(fifo_read);
        while (cyc < 467) begin
            tick();
            if (cyc < 432) nrd += int'(fifo_read);
            if (cyc >= 307 && cyc <= 309) check_eq("starve_black", {red, green, blue}, 0);
            if (cyc == 310) check_eq("starve_next", {red, green, blue}, {5'd1, 6'd2, 5'd31});
            if (cyc == 311) check_eq("starve_next2", {red, green, blue}, {5'd1, 6'd3, 5'd31});
            if (cyc == 307) check_eq("underrun_set", underrun, 1);
            if (cyc == 460) check_eq("underrun_sticky", underrun, 1);
            if (cyc == 306) begin
                check_eq("underrun_clean", underrun, 0);
                force_empty = 1'b1;
                #1;
                check_eq("no_read_on_empty", fifo_read, 0);
            end
            if (cyc == 309) force_empty = 1'b0;
        end
        check_eq("reads_starved_frame", nrd, 29);

        // ---------------- phase 4: 1-cycle reset at (3,2) ----------------
        reset = 1'b1;
        tick();
        check_eq("midrst_hsync", hsync, 1);
        check_eq("midrst_vsync", vsync, 1);
        check_eq("midrst_rgb", {red, green, blue}, 0);
        check_eq("midrst_trigger", trigger, 0);
        check_eq("midrst_underrun", underrun, 0);
        check_eq("midrst_read", fifo_read, 0);
        reset = 1'b0;
        cyc = 0;
        nrd = int'(fifo_read);
        while (cyc < 82) begin
            tick();
            if (cyc <= 80) nrd += int'(fifo_read);
            if (cyc == 80) check_eq("midrst_trig_early", trigger, 0);
            if (cyc == 81) check_eq("midrst_trig", trigger, 1);
        end
        check_eq("midrst_idle_reads", nrd, 0);
        check_eq("midrst_underrun_end", underrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
